// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: core-wide fetch states and PC constants
package fetch_pc_unit_pkg;
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;
  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// next_pc_sel: priority next-PC mux (halt > jump_reg > branch > +4) with alignment flag
module next_pc_sel
  import fetch_pc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        halt,
  input  logic        jump_reg,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  output logic [31:0] next_pc,
  output logic        misaligned
);
  always_comb begin
    next_pc = halt ? pc :
              jump_reg ? jump_target :
              branch_taken ? pc + branch_offset :
              pc + WORD_BYTES;
    misaligned = |next_pc[1:0];
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register, fetch req/ack sequencing, retire counter
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  input  logic             ex_done,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump_reg,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             halt,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             halted,
  output logic             error,
  output logic [WIDTH-1:0] retired_count
);
  state_t      state;
  logic [31:0] pc, next_pc;
  logic        misaligned;
  next_pc_sel u_sel (
    .pc(pc), .halt(halt), .jump_reg(jump_reg), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .next_pc(next_pc), .misaligned(misaligned)
  );
  assign pc_out    = pc;
  assign imem_addr = pc;
  assign pc_plus4  = pc + WORD_BYTES;
  // an ack only counts while our request is actually on the bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_FETCH;
      pc            <= RESET_PC;
      instr         <= '0;
      retired_count <= '0;
      imem_req      <= 1'b0;
      instr_valid   <= 1'b0;
      halted        <= 1'b0;
      error         <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_req && imem_ack) begin
            instr       <= imem_rdata;
            state       <= S_EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end else begin
            imem_req <= 1'b1;
          end
        end
        S_EXEC: begin
          if (ex_done) begin
            retired_count <= retired_count + 32'd1;
            instr_valid   <= 1'b0;
            if (!misaligned) pc <= next_pc;
            if (halt || misaligned) begin
              state  <= S_HALT;
              halted <= 1'b1;
              error  <= misaligned;
            end else begin
              state    <= S_FETCH;
              imem_req <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;
  logic        clk = 0, rst = 1;
  logic        imem_ack = 0, ex_done = 0, branch_taken = 0, jump_reg = 0, halt = 0;
  logic [31:0] imem_rdata = 0, branch_offset = 0, jump_target = 0;
  logic        imem_req, instr_valid, halted, error;
  logic [31:0] imem_addr, instr, pc_out, pc_plus4, retired_count;
  logic        b_ack = 0, b_ex_done = 0;
  logic        b_req, b_valid, b_halted, b_error;
  logic [31:0] b_addr, b_instr, b_pc, b_pc4, b_retired;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .ex_done(ex_done), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump_reg(jump_reg), .jump_target(jump_target),
    .halt(halt), .pc_out(pc_out), .pc_plus4(pc_plus4), .halted(halted),
    .error(error), .retired_count(retired_count)
  );

  fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ack(b_ack), .imem_rdata(32'h0000_0013), .instr(b_instr),
    .instr_valid(b_valid), .ex_done(b_ex_done), .branch_taken(1'b0),
    .branch_offset(32'h0), .jump_reg(1'b0), .jump_target(32'h0),
    .halt(1'b0), .pc_out(b_pc), .pc_plus4(b_pc4), .halted(b_halted),
    .error(b_error), .retired_count(b_retired)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    #2;
    rst = 0;
    tick();
  endtask

  initial begin
    #1;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_error", {31'b0, error}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_retired", retired_count, 32'h0);
    #1 rst = 0;
    tick();
    chk("t1_req_rise", {31'b0, imem_req}, 32'h1);
    chk("t1_addr", imem_addr, 32'h0);
    tick();
    tick();
    chk("t1_req_held", {31'b0, imem_req}, 32'h1);
    chk("t1_addr_held", imem_addr, 32'h0);
    imem_ack = 1; imem_rdata = 32'hDEADBEEF;
    tick();
    imem_ack = 0;
    chk("t1_instr", instr, 32'hDEADBEEF);
    chk("t1_valid", {31'b0, instr_valid}, 32'h1);
    chk("t1_req_drop", {31'b0, imem_req}, 32'h0);
    tick();
    chk("t1_exec_wait", {31'b0, instr_valid}, 32'h1);
    chk("t1_pc_hold", pc_out, 32'h0);

    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("t2_addr", imem_addr, 32'(4 * i));
      chk("t2_req", {31'b0, imem_req}, 32'h1);
      imem_ack = 1; imem_rdata = 32'h100 + 32'(i);
      tick();
      imem_ack = 0;
      chk("t2_instr", instr, 32'h100 + 32'(i));
      chk("t2_valid", {31'b0, instr_valid}, 32'h1);
      ex_done = 1;
      tick();
      ex_done = 0;
    end
    chk("t2_pc", pc_out, 32'hC);
    chk("t2_retired", retired_count, 32'd3);
    chk("t2_pc4", pc_plus4, 32'h10);

    imem_ack = 1; tick(); imem_ack = 0;
    ex_done = 1; tick(); ex_done = 0;
    chk("t3_pc_10", pc_out, 32'h10);
    imem_ack = 1; tick(); imem_ack = 0;
    ex_done = 1; branch_taken = 1; branch_offset = 32'hFFFF_FFF8;
    tick();
    ex_done = 0; branch_taken = 0;
    chk("t3_branch", imem_addr, 32'h8);
    chk("t3_branch_req", {31'b0, imem_req}, 32'h1);
    imem_ack = 1; tick(); imem_ack = 0;
    ex_done = 1; jump_reg = 1; jump_target = 32'h100; branch_taken = 1;
    tick();
    ex_done = 0; jump_reg = 0; branch_taken = 0;
    chk("t3_jump", imem_addr, 32'h100);
    chk("t3_jump_pc4", pc_plus4, 32'h104);
    chk("t3_retired", retired_count, 32'd6);

    imem_ack = 1; imem_rdata = 32'hCAFE0001; tick(); imem_ack = 0;
    ex_done = 1; halt = 1; branch_taken = 1;
    tick();
    ex_done = 0; halt = 0; branch_taken = 0;
    chk("t4_halted", {31'b0, halted}, 32'h1);
    chk("t4_pc", pc_out, 32'h100);
    chk("t4_retired", retired_count, 32'd7);
    chk("t4_req", {31'b0, imem_req}, 32'h0);
    chk("t4_valid", {31'b0, instr_valid}, 32'h0);
    chk("t4_error", {31'b0, error}, 32'h0);
    imem_ack = 1; imem_rdata = 32'h12345678; ex_done = 1;
    tick();
    tick();
    imem_ack = 0; ex_done = 0;
    chk("t4_stray_instr", instr, 32'hCAFE0001);
    chk("t4_stray_req", {31'b0, imem_req}, 32'h0);
    chk("t4_stray_pc", pc_out, 32'h100);
    chk("t4_stray_retired", retired_count, 32'd7);

    do_reset();
    imem_ack = 1; tick(); imem_ack = 0;
    ex_done = 1; jump_reg = 1; jump_target = 32'h102;
    tick();
    ex_done = 0; jump_reg = 0;
    chk("t5_error", {31'b0, error}, 32'h1);
    chk("t5_halted", {31'b0, halted}, 32'h1);
    chk("t5_pc", pc_out, 32'h0);
    chk("t5_retired", retired_count, 32'd1);
    chk("t5b_addr", b_addr, 32'hFFFF_FFFC);
    chk("t5b_pc4", b_pc4, 32'h0);
    b_ack = 1; tick(); b_ack = 0;
    chk("t5b_valid", {31'b0, b_valid}, 32'h1);
    b_ex_done = 1; tick(); b_ex_done = 0;
    chk("t5b_wrap", b_addr, 32'h0);
    chk("t5b_req", {31'b0, b_req}, 32'h1);
    chk("t5b_retired", b_retired, 32'd1);

    rst = 1;
    #1;
    chk("t6_halt_async_halted", {31'b0, halted}, 32'h0);
    chk("t6_halt_async_error", {31'b0, error}, 32'h0);
    chk("t6_halt_async_ret", retired_count, 32'h0);
    #1 rst = 0;
    tick();
    imem_ack = 1; tick(); imem_ack = 0;
    ex_done = 1; tick(); ex_done = 0;
    tick();
    chk("t6_pre_req", {31'b0, imem_req}, 32'h1);
    chk("t6_pre_pc", pc_out, 32'h4);
    rst = 1;
    #1;
    chk("t6_req", {31'b0, imem_req}, 32'h0);
    chk("t6_valid", {31'b0, instr_valid}, 32'h0);
    chk("t6_halted", {31'b0, halted}, 32'h0);
    chk("t6_error", {31'b0, error}, 32'h0);
    chk("t6_pc", pc_out, 32'h0);
    chk("t6b_pc", b_pc, 32'hFFFF_FFFC);
    #1 rst = 0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
